// File: rtl/eth_frame_pattern_matcher_if.sv
// rtl/eth_frame_pattern_matcher_if.sv - frame stream, pattern-memory read port and verdict bundle
//
// Groups the signals exchanged between the pattern matcher and its
// surroundings. The matcher connects through the slave modport; the frame
// source / pattern memory / verdict consumer side uses the master modport.
//
// Signals:
//   s_axis_tdata  [7:0]         frame byte
//   s_axis_tvalid               byte valid (gaps allowed, no backpressure)
//   s_axis_tlast                last byte of frame
//   s_axis_tuser                frame error, meaningful only with tlast
//   mem_pb_addr   [10:0]        pattern word address (matcher -> memory)
//   mem_pb_rdata  [C_AXI_WIDTH] pattern word, one clock after its address
//   match_valid                 one-cycle verdict strobe
//   match                       verdict, qualified by match_valid

interface eth_frame_pattern_matcher_if #(
  parameter int C_AXI_WIDTH = 32
);

  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tlast;
  logic                   s_axis_tuser;
  logic [10:0]            mem_pb_addr;
  logic [C_AXI_WIDTH-1:0] mem_pb_rdata;
  logic                   match_valid;
  logic                   match;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    output s_axis_tuser,
    output mem_pb_rdata,
    input  mem_pb_addr,
    input  match_valid,
    input  match
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    input  s_axis_tuser,
    input  mem_pb_rdata,
    output mem_pb_addr,
    output match_valid,
    output match
  );

endinterface

// File: rtl/eth_frame_pattern_matcher.sv
// rtl/eth_frame_pattern_matcher.sv - masked byte comparator walking the pattern memory per frame
//
// Walks the pattern memory in step with an incoming Ethernet frame and
// compares each frame byte k against pattern word k under a per-byte mask,
// producing one match/no-match verdict per frame. Runs entirely in the
// pattern memory read-port clock domain.
//
// Pattern word layout: [7:0] data, [15:8] mask (1 = compare bit),
// [16] end marker (byte k is the final pattern byte), upper bits ignored.
//
// Ports:
//   clk     in   read-port clock (same net as mem_pb_clk)
//   rst     in   synchronous active-high reset
//   enable  in   detection enable, sampled on the first beat of a frame
//   bus     slave modport of eth_frame_pattern_matcher_if:
//             s_axis_tdata/tvalid/tlast/tuser in, mem_pb_rdata in,
//             mem_pb_addr out, match_valid out, match out
//
// Build option ETH_FRAME_MATCHER_EARLY_EN: when defined, entering HIT
// reports match=1 immediately instead of waiting for tlast, and a frame
// already reported gives no second strobe at tlast.

module eth_frame_pattern_matcher #(
  parameter int C_AXI_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  eth_frame_pattern_matcher_if.slave bus
);

  localparam logic [10:0] IDX_MAX = 11'd2047;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    HIT,
    MISS
  } state_t;

  // Stage 0: byte index, doubles as the pattern memory address.
  logic [10:0] idx;

  // Stage 1: the accepted beat, aligned with the pattern word it addressed.
  logic        st_valid;
  logic [7:0]  st_byte;
  logic        st_first;
  logic        st_last;
  logic        st_user;
  logic        st_enable;
  logic        st_sat;

  // Pattern word fields.
  logic [C_AXI_WIDTH-1:0] rdata;
  logic [7:0]             pat_data;
  logic [7:0]             pat_mask;
  logic                   pat_end;
  logic                   byte_ok;

  state_t state;
  state_t cmp_next;
  state_t step_next;

  logic match_valid_q;
  logic match_q;

  assign rdata    = bus.mem_pb_rdata;
  assign pat_data = rdata[7:0];
  assign pat_mask = rdata[15:8];
  assign pat_end  = rdata[16];

  generate
    if (C_AXI_WIDTH > 17) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^rdata[C_AXI_WIDTH-1:17];
    end
  endgenerate

  assign bus.mem_pb_addr = idx;
  assign bus.match_valid = match_valid_q;
  assign bus.match       = match_q;

  // Stage 0 -> stage 1. The index saturates so that arbitrarily long frames
  // keep re-reading the last pattern word rather than wrapping to word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      st_valid  <= 1'b0;
      st_byte   <= '0;
      st_first  <= 1'b0;
      st_last   <= 1'b0;
      st_user   <= 1'b0;
      st_enable <= 1'b0;
      st_sat    <= 1'b0;
    end else begin
      st_valid <= bus.s_axis_tvalid;
      if (bus.s_axis_tvalid) begin
        st_byte   <= bus.s_axis_tdata;
        st_last   <= bus.s_axis_tlast;
        st_user   <= bus.s_axis_tuser;
        st_enable <= enable;
        // idx is only 0 on a frame's first beat: it returns to 0 after tlast
        // or reset and never wraps.
        st_first  <= (idx == '0);
        st_sat    <= (idx == IDX_MAX);
        if (bus.s_axis_tlast) begin
          idx <= '0;
        end else if (idx != IDX_MAX) begin
          idx <= idx + 11'd1;
        end
      end
    end
  end

  // Stage 1 byte comparison against the word addressed one clock earlier.
  assign byte_ok = ((st_byte ^ pat_data) & pat_mask) == 8'h00;

  // Outcome of one comparison step while armed. A matching byte at the
  // saturated index without a marker can never be followed by the marker,
  // so it is a miss.
  always_comb begin
    cmp_next = COMPARE;
    if (!byte_ok) begin
      cmp_next = MISS;
    end else if (pat_end) begin
      cmp_next = HIT;
    end else if (st_sat) begin
      cmp_next = MISS;
    end
  end

  // State after the staged beat. IDLE only arms on a first beat, so a
  // single-byte frame gets its full comparison in the same step.
  always_comb begin
    step_next = state;
    case (state)
      IDLE: begin
        if (st_first) begin
          step_next = st_enable ? cmp_next : MISS;
        end
      end
      COMPARE: step_next = cmp_next;
      default: step_next = state;
    endcase
  end

`ifdef ETH_FRAME_MATCHER_EARLY_EN
  // The early verdict is always a match, so the frame error is not used.
  logic unused_st_user;
  assign unused_st_user = st_user;
`endif

  // Verdict FSM with registered strobe/verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      match_valid_q <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      match_valid_q <= 1'b0;
      if (st_valid) begin
        if (st_last) begin
          state <= IDLE;
`ifdef ETH_FRAME_MATCHER_EARLY_EN
          // Being in HIT already means the frame was reported on entry.
          if (state != HIT) begin
            match_valid_q <= 1'b1;
            match_q       <= (step_next == HIT);
          end
`else
          match_valid_q <= 1'b1;
          match_q       <= (step_next == HIT) && !st_user;
`endif
        end else begin
          state <= step_next;
`ifdef ETH_FRAME_MATCHER_EARLY_EN
          if ((step_next == HIT) && (state != HIT)) begin
            match_valid_q <= 1'b1;
            match_q       <= 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule
